keccak_pad_stream: RTL

- Streaming multi-rate padding unit for the Keccak sponge.
- Accepts message words over a valid/ready interface and inserts the domain separator and the 10*1 terminator.
- Generates any extra zero/pad words needed to complete the final block, and tags block boundaries for the absorb stage.
- Sits between the input FIFO and the state-XOR/permutation controller. Replaces the per-word combinational padder with one that owns the block word counter and runtime rate selection.

---
 rtl/keccak_pad_stream_pkg.sv | 42 ++++
 rtl/keccak_pad_stream_pad_word_builder.sv | 43 ++++
 rtl/keccak_pad_stream.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/keccak_pad_stream_pkg.sv
// Shared definitions for the streaming Keccak padder: mode codes, domain
// separator bytes, the 10*1 terminator byte, rate lookup and FSM encodings.
// The SHA3 modes are only reachable when KECCAK_PAD_SHA3_EN is defined.
package keccak_pkg_mine;

    typedef enum logic [1:0] {
        SHAKE128 = 2'd0,
        SHAKE256 = 2'd1,
        SHA3_256 = 2'd2,
        SHA3_512 = 2'd3
    } pad_mode_t;

    typedef enum logic [1:0] {
        MSG       = 2'd0,
        PAD_FIRST = 2'd1,
        FILL      = 2'd2
    } pad_state_t;

    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] DS_SHA3  = 8'h06;
    localparam logic [7:0] PAD_TERM = 8'h80;

    // Sponge rate in bytes for each mode.
    function automatic int unsigned rate_bytes(input pad_mode_t m);
        case (m)
            SHAKE128: return 168;
            SHAKE256: return 136;
            SHA3_256: return 136;
            SHA3_512: return 72;
            default:  return 168;
        endcase
    endfunction

    // Domain separation byte for each mode.
    function automatic logic [7:0] ds_of(input pad_mode_t m);
        case (m)
            SHA3_256, SHA3_512: return DS_SHA3;
            default:            return DS_SHAKE;
        endcase
    endfunction

endpackage

// File: rtl/keccak_pad_stream_pad_word_builder.sv
// Combinational padded-word builder. Keeps the first nbytes bytes of data
// (byte k lives at bits [W-1-8k -: 8]), optionally drops the domain separator
// into byte nbytes, zeroes the rest and ORs the terminator into the last byte
// when the word closes a rate block.
module pad_word_builder
    import keccak_pkg_mine::*;
#(
    parameter int W  = 64,
    parameter int WB = W / 8
) (
    input  logic [W-1:0]          data,
    input  logic [$clog2(WB):0]   nbytes,
    input  logic                  is_first_pad,
    input  logic                  is_block_end,
    input  logic [7:0]            ds,
    output logic [W-1:0]          word
);
    localparam int NB_W = $clog2(WB) + 1;

    genvar gi;
    generate
        for (gi = 0; gi < WB; gi++) begin : g_byte
            logic [7:0] byte_val;

            // Select data, separator or zero for this byte lane, then apply the terminator.
            always_comb begin
                if (NB_W'(gi) < nbytes) begin
                    byte_val = data[W-1-8*gi -: 8];
                end else if (is_first_pad && (NB_W'(gi) == nbytes)) begin
                    byte_val = ds;
                end else begin
                    byte_val = 8'h00;
                end
                if ((gi == WB - 1) && is_block_end) begin
                    byte_val = byte_val | PAD_TERM;
                end
            end

            assign word[W-1-8*gi -: 8] = byte_val;
        end
    endgenerate

endmodule

// File: rtl/keccak_pad_stream.sv
// Streaming multi-rate Keccak padder. Passes message words through a single
// output register, inserts the domain separator and 10*1 terminator, generates
// any trailing pad/zero words and tags block ends and the final block.
// Optional SHA3 modes are enabled by defining KECCAK_PAD_SHA3_EN.
module keccak_pad_stream
    import keccak_pkg_mine::*;
#(
    parameter int W     = 64,
    parameter int WB    = W / 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic                 in_last,
    input  logic [$clog2(WB):0]  in_bytes,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic                 out_block_end,
    output logic                 out_last_block
);
    localparam int NB_W = $clog2(WB) + 1;

    localparam logic [1:0] ST_MSG       = MSG;
    localparam logic [1:0] ST_PAD_FIRST = PAD_FIRST;
    localparam logic [1:0] ST_FILL      = FILL;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    pad_mode_t        mode_reg;
    logic             msg_active_reg;
    logic             out_valid_reg;
    logic [W-1:0]     out_data_reg;
    logic             out_block_end_reg;
    logic             out_last_block_reg;

    pad_mode_t        mode_pin;
    pad_mode_t        mode_cur;
    logic [CNT_W-1:0] rate_last;
    logic             is_be;
    logic             stage_free;
    logic             accept;
    logic [NB_W-1:0]  nb_clamp;
    logic             is_partial;
    logic             word_load;
    logic             lb_word;

    logic [NB_W-1:0]  b_nbytes;
    logic             b_first;
    logic             b_be;
    logic [W-1:0]     b_word;

`ifdef KECCAK_PAD_SHA3_EN
    assign mode_pin = pad_mode_t'(mode);
`else
    // Only the SHAKE pair exists here; the upper mode bit has no meaning.
    logic unused_mode_bit;
    assign unused_mode_bit = mode[1];
    assign mode_pin = mode[0] ? SHAKE256 : SHAKE128;
`endif

    // Mode comes from the pins on a message's first word, from the latch afterwards.
    always_comb begin
        mode_cur   = msg_active_reg ? mode_reg : mode_pin;
        rate_last  = CNT_W'(rate_bytes(mode_cur) / WB - 1);
        is_be      = (cnt_reg == rate_last);
        stage_free = !out_valid_reg || out_ready;
        in_ready   = !rst && (state_reg == ST_MSG) && stage_free;
        accept     = in_valid && in_ready;
        nb_clamp   = (in_bytes > NB_W'(WB)) ? NB_W'(WB) : in_bytes;
        is_partial = nb_clamp < NB_W'(WB);
    end

    // Builder controls: which bytes are kept, where the separator goes, terminator.
    always_comb begin
        b_nbytes = NB_W'(WB);
        b_first  = 1'b0;
        b_be     = 1'b0;
        case (state_reg)
            ST_MSG: begin
                if (in_last && is_partial) begin
                    b_nbytes = nb_clamp;
                    b_first  = 1'b1;
                    b_be     = is_be;
                end
            end
            ST_PAD_FIRST: begin
                b_nbytes = '0;
                b_first  = 1'b1;
                b_be     = is_be;
            end
            ST_FILL: begin
                b_nbytes = '0;
                b_be     = is_be;
            end
            default: ;
        endcase
    end

    pad_word_builder #(
        .W  (W),
        .WB (WB)
    ) u_builder (
        .data         (in_data),
        .nbytes       (b_nbytes),
        .is_first_pad (b_first),
        .is_block_end (b_be),
        .ds           (ds_of(mode_cur)),
        .word         (b_word)
    );

    // Next-state logic: a state only advances together with a loaded word.
    always_comb begin
        state_next = state_reg;
        word_load  = 1'b0;
        lb_word    = 1'b0;
        case (state_reg)
            ST_MSG: begin
                word_load = accept;
                if (accept && in_last) begin
                    if (is_partial) begin
                        lb_word    = 1'b1;
                        state_next = is_be ? ST_MSG : ST_FILL;
                    end else begin
                        // Full last word: padding starts in the next word,
                        // which opens a new block if this one closes a block.
                        state_next = ST_PAD_FIRST;
                    end
                end
            end
            ST_PAD_FIRST, ST_FILL: begin
                word_load = stage_free;
                lb_word   = 1'b1;
                if (stage_free) begin
                    state_next = is_be ? ST_MSG : ST_FILL;
                end
            end
            default: state_next = ST_MSG;
        endcase
    end

    // Output stage, block counter, FSM and mode latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_MSG;
            cnt_reg            <= '0;
            mode_reg           <= SHAKE128;
            msg_active_reg     <= 1'b0;
            out_valid_reg      <= 1'b0;
            out_data_reg       <= '0;
            out_block_end_reg  <= 1'b0;
            out_last_block_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (stage_free) begin
                out_valid_reg <= word_load;
            end
            if (word_load) begin
                out_data_reg       <= b_word;
                out_block_end_reg  <= is_be;
                out_last_block_reg <= lb_word;
                cnt_reg            <= is_be ? '0 : cnt_reg + CNT_W'(1);
                // The message stays open until its final block-end word leaves.
                msg_active_reg     <= !(lb_word && is_be);
            end
            if (accept && !msg_active_reg) begin
                mode_reg <= mode_pin;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign out_data       = out_data_reg;
    assign out_block_end  = out_block_end_reg;
    assign out_last_block = out_last_block_reg;

endmodule
